dp_seq_ctrl: RTL and testbench
==============================

Name: dp_seq_ctrl

Overview:
Multi-cycle sequencer for the data-processing datapath. It takes the decoded fields of the current instruction (condition code, S, TTCC, undefined-instruction flag) and the current NZCV flags. It steps the datapath through fetch, decode/condition-check, operand read, execute and write-back by driving one-cycle latch and write strobes. It sits between the instruction decoder and the register file / shifter / ALU / flag register.

Parameters:
CNT_W, 16, width of the retired-instruction counter; wraps modulo 2^CNT_W.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
run  input  1  level; 1 = keep fetching instructions.
err_clr  input  1  one-cycle pulse; leaves the UND state.
cond  input  4  instruction condition field, I[31:28].
nzcv  input  4  current flags: [3]N [2]Z [1]C [0]V.
S  input  1  decoded S bit.
TTCC  input  1  decoded compare/test (no register write-back).
Und_Ins  input  1  decoded undefined-instruction flag.
Write_IR  output  1  latch instruction register.
Write_PC  output  1  PC <= PC+4.
LA  output  1  latch operand A (rn).
LB  output  1  latch operand B (rm/imm).
LC  output  1  latch shift amount (rs/imm5).
LF  output  1  latch ALU result register F.
Write_Flag  output  1  flag register write enable.
Write_Reg  output  1  register-file write of F to rd.
cond_ok  output  1  combinational condition-pass for cond/nzcv.
und_err  output  1  high while in UND.
busy  output  1  high in any state except IDLE and UND.
state  output  3  current state code.
instr_cnt  output  CNT_W  retired + skipped instruction count.

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, READ=3, EXEC=4, WB=5, UND=6. Code 7 is unreachable; if entered, go to IDLE next cycle.
- All strobes are Moore outputs decoded from state. Each strobe is high only in the state listed below, for exactly one cycle per visit.
- Reset (asynchronous, any time, including mid-instruction): state=IDLE, instr_cnt=0. All strobes, und_err and busy are 0.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: Write_IR=1, Write_PC=1 -> DECODE.
- DECODE, priority order:
  - Und_Ins=1 -> UND (cond is not evaluated).
  - Else cond_ok=0 -> instruction is skipped: instr_cnt+1, then FETCH if run=1, else IDLE.
  - Else -> READ.
- READ: LA=LB=LC=1 -> EXEC.
- EXEC: LF=1; Write_Flag=S -> WB.
- WB: Write_Reg = ~TTCC; instr_cnt+1; then FETCH if run=1, else IDLE.
- UND: und_err=1, no strobes, instr_cnt unchanged. err_clr=1 -> IDLE (even if run=1). Otherwise stay.
- err_clr outside UND is ignored.
- run=0 mid-instruction does not abort; the instruction finishes and the FSM then goes to IDLE.
- Latency: an executed instruction takes 5 cycles (FETCH..WB); a skipped one takes 2 cycles (FETCH, DECODE).
- Flags written at the end of EXEC are visible to the next instruction's DECODE.
- cond_ok truth, with N,Z,C,V from nzcv:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z.
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- instr_cnt wraps from 2^CNT_W-1 to 0 without any flag.

Test Plan:
- Reset then run=1, cond=E, S=1, TTCC=0, Und_Ins=0 -> state sequence 1,2,3,4,5,1. Write_Flag=1 only in state 4, Write_Reg=1 only in state 5; instr_cnt=1 after WB.
- cond=0 (EQ), nzcv=4'b0000 -> skip: states 1,2,1. No LA/LF/Write_Reg; instr_cnt increments. Repeat with nzcv=4'b0100 -> full 5-cycle path.
- TTCC=1, S=1, cond=E -> Write_Flag=1 in EXEC, Write_Reg=0 in WB; instr_cnt still increments.
- Und_Ins=1 in DECODE -> UND, und_err=1, busy=0, held for 10 cycles. err_clr pulse with run=1 -> IDLE next cycle, then FETCH.
- Sweep all 16 cond values against all 16 nzcv values -> cond_ok matches the table (256 checks). Include GT with nzcv=4'b1001 -> 1, and LE with nzcv=4'b1000 -> 1.
- CNT_W=4: run 16 instructions -> instr_cnt returns to 0. Assert rst during EXEC -> IDLE immediately, all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/dp_seq_ctrl.sv
// Multi-cycle sequencer for the data-processing datapath: FETCH, DECODE/cond-check, READ, EXEC, WB.
// Latency: 5 cycles per executed instruction, 2 cycles per condition-skipped one; strobes are Moore, 1 cycle each.
// No backpressure: 'run' gates new fetches only, an in-flight instruction always completes.
module dp_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             err_clr,
    input  logic [3:0]       cond,
    input  logic [3:0]       nzcv,
    input  logic             S,
    input  logic             TTCC,
    input  logic             Und_Ins,
    output logic             Write_IR,
    output logic             Write_PC,
    output logic             LA,
    output logic             LB,
    output logic             LC,
    output logic             LF,
    output logic             Write_Flag,
    output logic             Write_Reg,
    output logic             cond_ok,
    output logic             und_err,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_UND    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t cur_state;
    state_t nxt_state;
    logic   flag_n, flag_z, flag_c, flag_v;
    logic   count_en;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    // Condition-code evaluation against the current flags
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = flag_z;
            4'h1: cond_ok = ~flag_z;
            4'h2: cond_ok = flag_c;
            4'h3: cond_ok = ~flag_c;
            4'h4: cond_ok = flag_n;
            4'h5: cond_ok = ~flag_n;
            4'h6: cond_ok = flag_v;
            4'h7: cond_ok = ~flag_v;
            4'h8: cond_ok = flag_c & ~flag_z;
            4'h9: cond_ok = ~flag_c | flag_z;
            4'hA: cond_ok = (flag_n == flag_v);
            4'hB: cond_ok = (flag_n != flag_v);
            4'hC: cond_ok = ~flag_z & (flag_n == flag_v);
            4'hD: cond_ok = flag_z | (flag_n != flag_v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic; DECODE checks the undefined flag before the condition
    always_comb begin
        nxt_state = ST_IDLE;
        case (cur_state)
            ST_IDLE:   nxt_state = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  nxt_state = ST_DECODE;
            ST_DECODE: begin
                if (Und_Ins) begin
                    nxt_state = ST_UND;
                end else if (!cond_ok) begin
                    nxt_state = run ? ST_FETCH : ST_IDLE;
                end else begin
                    nxt_state = ST_READ;
                end
            end
            ST_READ:   nxt_state = ST_EXEC;
            ST_EXEC:   nxt_state = ST_WB;
            ST_WB:     nxt_state = run ? ST_FETCH : ST_IDLE;
            ST_UND:    nxt_state = err_clr ? ST_IDLE : ST_UND;
            default:   nxt_state = ST_IDLE;
        endcase
    end

    // Moore strobe decode; S and TTCC only qualify the EXEC/WB write enables
    always_comb begin
        Write_IR   = 1'b0;
        Write_PC   = 1'b0;
        LA         = 1'b0;
        LB         = 1'b0;
        LC         = 1'b0;
        LF         = 1'b0;
        Write_Flag = 1'b0;
        Write_Reg  = 1'b0;
        und_err    = 1'b0;
        busy       = 1'b0;
        case (cur_state)
            ST_FETCH: begin
                Write_IR = 1'b1;
                Write_PC = 1'b1;
                busy     = 1'b1;
            end
            ST_DECODE: busy = 1'b1;
            ST_READ: begin
                LA   = 1'b1;
                LB   = 1'b1;
                LC   = 1'b1;
                busy = 1'b1;
            end
            ST_EXEC: begin
                LF         = 1'b1;
                Write_Flag = S;
                busy       = 1'b1;
            end
            ST_WB: begin
                Write_Reg = ~TTCC;
                busy      = 1'b1;
            end
            ST_UND:  und_err = 1'b1;
            default: ;
        endcase
    end

    // An instruction counts once it retires from WB or is dropped by a failed condition
    assign count_en = (cur_state == ST_WB) ||
                      ((cur_state == ST_DECODE) && !Und_Ins && !cond_ok);

    // Retired/skipped instruction counter, free-running wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
        end else if (count_en) begin
            instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
module tb_dp_seq_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             run, err_clr, S, TTCC, Und_Ins;
    logic [3:0]       cond, nzcv;
    logic             Write_IR, Write_PC, LA, LB, LC, LF, Write_Flag, Write_Reg;
    logic             cond_ok, und_err, busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: which step of the instruction we are in, plus the count
    int m_st;
    int m_cnt;

    dp_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .err_clr(err_clr),
        .cond(cond), .nzcv(nzcv), .S(S), .TTCC(TTCC), .Und_Ins(Und_Ins),
        .Write_IR(Write_IR), .Write_PC(Write_PC), .LA(LA), .LB(LB), .LC(LC),
        .LF(LF), .Write_Flag(Write_Flag), .Write_Reg(Write_Reg),
        .cond_ok(cond_ok), .und_err(und_err), .busy(busy),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Condition table folded into pairs: odd codes are the inverse of the even ones
    function automatic bit mdl_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check_all();
        chk("state",      {29'd0, state},          m_st);
        chk("Write_IR",   {31'd0, Write_IR},       (m_st == 1) ? 1 : 0);
        chk("Write_PC",   {31'd0, Write_PC},       (m_st == 1) ? 1 : 0);
        chk("LA",         {31'd0, LA},             (m_st == 3) ? 1 : 0);
        chk("LB",         {31'd0, LB},             (m_st == 3) ? 1 : 0);
        chk("LC",         {31'd0, LC},             (m_st == 3) ? 1 : 0);
        chk("LF",         {31'd0, LF},             (m_st == 4) ? 1 : 0);
        chk("Write_Flag", {31'd0, Write_Flag},     (m_st == 4 && S) ? 1 : 0);
        chk("Write_Reg",  {31'd0, Write_Reg},      (m_st == 5 && !TTCC) ? 1 : 0);
        chk("und_err",    {31'd0, und_err},        (m_st == 6) ? 1 : 0);
        chk("busy",       {31'd0, busy},           (m_st >= 1 && m_st <= 5) ? 1 : 0);
        chk("cond_ok",    {31'd0, cond_ok},        mdl_cond(cond, nzcv));
        chk("instr_cnt",  {28'd0, instr_cnt},      m_cnt);
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge
    task automatic cycle();
        int nxt;
        #4;
        check_all();
        nxt = 0;
        case (m_st)
            0: nxt = run ? 1 : 0;
            1: nxt = 2;
            2: begin
                if (Und_Ins) nxt = 6;
                else if (!mdl_cond(cond, nzcv)) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    nxt = run ? 1 : 0;
                end else nxt = 3;
            end
            3: nxt = 4;
            4: nxt = 5;
            5: begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                nxt = run ? 1 : 0;
            end
            6: nxt = err_clr ? 0 : 6;
            default: nxt = 0;
        endcase
        @(posedge clk);
        #1;
        m_st = nxt;
    endtask

    task automatic seq(input int exp_st);
        cycle();
        chk("seq_state", {29'd0, state}, exp_st);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; err_clr = 1'b0; S = 1'b0; TTCC = 1'b0;
        Und_Ins = 1'b0; cond = 4'h0; nzcv = 4'h0;
        m_st = 0; m_cnt = 0;

        // Combinational condition sweep while reset holds the FSM
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                cond = c[3:0];
                nzcv = f[3:0];
                #0.1;
                chk("cond_sweep", {31'd0, cond_ok}, mdl_cond(cond, nzcv));
            end
        end
        cond = 4'hC; nzcv = 4'b1001; #0.1;
        chk("cond_GT_1001", {31'd0, cond_ok}, 1);
        cond = 4'hD; nzcv = 4'b1000; #0.1;
        chk("cond_LE_1000", {31'd0, cond_ok}, 1);
        cond = 4'h0; nzcv = 4'b0000; #0.1;
        chk("cond_EQ_0000", {31'd0, cond_ok}, 0);
        cond = 4'hF; nzcv = 4'b0100; #0.1;
        chk("cond_NV", {31'd0, cond_ok}, 0);

        #12;
        check_all();
        chk("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // One always-executed instruction with flag write
        run = 1'b1; cond = 4'hE; S = 1'b1; TTCC = 1'b0; Und_Ins = 1'b0; nzcv = 4'h0;
        seq(1); seq(2); seq(3); seq(4);
        chk("wflag_exec", {31'd0, Write_Flag}, 1);
        seq(5);
        chk("wreg_wb", {31'd0, Write_Reg}, 1);
        seq(1);
        chk("cnt_after_wb", {28'd0, instr_cnt}, 1);

        // EQ with Z clear is skipped, with Z set it executes
        cond = 4'h0; nzcv = 4'b0000;
        seq(2); seq(1);
        chk("cnt_skip", {28'd0, instr_cnt}, 2);
        nzcv = 4'b0100;
        seq(2); seq(3); seq(4); seq(5); seq(1);
        chk("cnt_eq", {28'd0, instr_cnt}, 3);

        // Compare/test: flags written, no register write-back
        cond = 4'hE; TTCC = 1'b1; S = 1'b1;
        seq(2); seq(3); seq(4);
        chk("ttcc_wflag", {31'd0, Write_Flag}, 1);
        seq(5);
        chk("ttcc_wreg", {31'd0, Write_Reg}, 0);
        seq(1);
        chk("cnt_ttcc", {28'd0, instr_cnt}, 4);
        TTCC = 1'b0;

        // Undefined instruction parks in UND until err_clr
        Und_Ins = 1'b1;
        seq(2); seq(6);
        Und_Ins = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("und_err_hold", {31'd0, und_err}, 1);
            chk("und_busy", {31'd0, busy}, 0);
            seq(6);
        end
        chk("cnt_und", {28'd0, instr_cnt}, 4);
        err_clr = 1'b1;
        seq(0);
        err_clr = 1'b0;
        seq(1);

        // Twelve more executed instructions make sixteen: a 4-bit count wraps to zero
        for (int i = 0; i < 12; i++) begin
            repeat (5) cycle();
        end
        chk("cnt_wrap", {28'd0, instr_cnt}, 0);

        // Asynchronous reset in the middle of EXEC
        seq(2); seq(3); seq(4);
        run = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_state", {29'd0, state}, 0);
        chk("rst_lf", {31'd0, LF}, 0);
        chk("rst_wflag", {31'd0, Write_Flag}, 0);
        chk("rst_busy_exec", {31'd0, busy}, 0);
        chk("rst_cnt", {28'd0, instr_cnt}, 0);
        m_st = 0; m_cnt = 0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            run     = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 3) == 0);
            Und_Ins = ($urandom_range(0, 15) == 0);
            S       = $urandom_range(0, 1);
            TTCC    = $urandom_range(0, 1);
            cond    = 4'($urandom_range(0, 15));
            nzcv    = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
